// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Command front-end for the 8-bit combinational ALU. It accepts one command
// per cmd_valid/cmd_ready handshake and drives the ALU operands and select
// from registers. It samples the ALU result and flags one cycle later and
// returns them over a rsp_valid/rsp_ready handshake. An internal accumulator
// lets chained operations reuse the previous result as operand A.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op, cmd_a, cmd_b        ALU select and operands
//   cmd_use_acc, cmd_wr_acc     take A from / write result to accumulator
//   acc_clr                     load ACC_INIT into accumulator (IDLE only)
//   alu_a, alu_b, alu_sel       registered ALU inputs
//   alu_out, alu_c..alu_p       ALU result and raw flags
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_flags         result and {err, p, z, s, ac, c}
//   acc                         current accumulator
//   cmd_count                   completed responses (wrapping)
module alu_cmd_sequencer #(
    parameter logic [7:0] ACC_INIT = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic        cmd_use_acc,
    input  logic        cmd_wr_acc,
    input  logic        acc_clr,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_sel,
    input  logic [7:0]  alu_out,
    input  logic        alu_c,
    input  logic        alu_ac,
    input  logic        alu_s,
    input  logic        alu_z,
    input  logic        alu_p,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [5:0]  rsp_flags,
    output logic [7:0]  acc,
    output logic [15:0] cmd_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_reg;
    logic        cmd_ready_reg;
    logic        rsp_valid_reg;
    logic [7:0]  alu_a_reg;
    logic [7:0]  alu_b_reg;
    logic [3:0]  alu_sel_reg;
    logic [3:0]  op_reg;
    logic        wr_acc_reg;
    logic [7:0]  rsp_data_reg;
    logic [5:0]  rsp_flags_reg;
    logic [7:0]  acc_reg;
    logic [15:0] cmd_count_reg;

    logic [7:0]  rsp_data_next;
    logic [5:0]  rsp_flags_next;
    logic        op_illegal;

    // Ops 12-15 have no ALU function behind them.
    assign op_illegal = (op_reg[3:2] == 2'b11);

    // The ALU's c/ac/s are only meaningful for the arithmetic/rotate group
    // (8-11), so they are masked or replaced here rather than trusted.
    always_comb begin
        rsp_data_next  = alu_out;
        rsp_flags_next = 6'b000000;
        if (op_illegal) begin
            rsp_data_next  = 8'h00;
            rsp_flags_next = 6'b100000;
        end else begin
            rsp_flags_next[4] = alu_p;
            rsp_flags_next[3] = alu_z;
            case (op_reg)
                4'd8, 4'd9: begin
                    rsp_flags_next[2] = alu_s;
                    rsp_flags_next[1] = alu_ac;
                    rsp_flags_next[0] = alu_c;
                end
                4'd10, 4'd11: begin
                    rsp_flags_next[2] = alu_out[7];
                    rsp_flags_next[0] = alu_c;
                end
                default: begin
                    rsp_flags_next[2] = alu_out[7];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cmd_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            alu_a_reg     <= 8'h00;
            alu_b_reg     <= 8'h00;
            alu_sel_reg   <= 4'h0;
            op_reg        <= 4'h0;
            wr_acc_reg    <= 1'b0;
            rsp_data_reg  <= 8'h00;
            rsp_flags_reg <= 6'h00;
            acc_reg       <= ACC_INIT;
            cmd_count_reg <= 16'h0000;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (acc_clr) begin
                        acc_reg <= ACC_INIT;
                    end
                    if (cmd_valid) begin
                        // A clear in the same cycle wins, so the command sees ACC_INIT.
                        if (cmd_use_acc) begin
                            alu_a_reg <= acc_clr ? ACC_INIT : acc_reg;
                        end else begin
                            alu_a_reg <= cmd_a;
                        end
                        alu_b_reg     <= cmd_b;
                        alu_sel_reg   <= (cmd_op[3:2] == 2'b11) ? 4'h0 : cmd_op;
                        op_reg        <= cmd_op;
                        wr_acc_reg    <= cmd_wr_acc;
                        state_reg     <= S_EXEC;
                        cmd_ready_reg <= 1'b0;
                    end
                end
                S_EXEC: begin
                    rsp_data_reg  <= rsp_data_next;
                    rsp_flags_reg <= rsp_flags_next;
                    state_reg     <= S_RESP;
                    rsp_valid_reg <= 1'b1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        if (wr_acc_reg && !rsp_flags_reg[5]) begin
                            acc_reg <= rsp_data_reg;
                        end
                        cmd_count_reg <= cmd_count_reg + 16'd1;
                        state_reg     <= S_IDLE;
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= S_IDLE;
                    rsp_valid_reg <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_sel   = alu_sel_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_flags = rsp_flags_reg;
    assign acc       = acc_reg;
    assign cmd_count = cmd_count_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: a behavioural ALU stub feeds the DUT.
// Commands are checked against a reference model at the response and
// accumulator level.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        cmd_use_acc;
    logic        cmd_wr_acc;
    logic        acc_clr;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_out;
    logic        alu_c, alu_ac, alu_s, alu_z, alu_p;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [5:0]  rsp_flags;
    logic [7:0]  acc;
    logic [15:0] cmd_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  acc_m;
    logic [15:0] cnt_m;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.ACC_INIT(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_use_acc(cmd_use_acc), .cmd_wr_acc(cmd_wr_acc), .acc_clr(acc_clr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_c(alu_c), .alu_ac(alu_ac), .alu_s(alu_s),
        .alu_z(alu_z), .alu_p(alu_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .acc(acc), .cmd_count(cmd_count)
    );

    // ALU behaviour: {c, ac, s, out}. Outside ops 8/9 the s flag is
    // deliberately wrong. Outside ops 8-11 the c flag is wrong. Outside
    // ops 8/9 the ac flag is wrong. This exposes missing masking.
    function automatic logic [10:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        logic [4:0] n;
        logic [7:0] o;
        logic       c, ac, s;
        c = 1'b1; ac = 1'b1; o = 8'hAA;
        t = '0; n = '0;
        case (op)
            4'd0: o = a & b;
            4'd1: o = a | b;
            4'd2: o = a ^ b;
            4'd3: o = ~a;
            4'd4: o = a;
            4'd5: o = {a[6:0], 1'b0};
            4'd6: o = a + 8'd1;
            4'd7: o = a - 8'd1;
            4'd8: begin
                t = {1'b0, a} + {1'b0, b};
                n = {1'b0, a[3:0]} + {1'b0, b[3:0]};
                o = t[7:0]; c = t[8]; ac = n[4];
            end
            4'd9: begin
                t = {1'b0, a} - {1'b0, b};
                n = {1'b0, a[3:0]} - {1'b0, b[3:0]};
                o = t[7:0]; c = t[8]; ac = n[4];
            end
            4'd10: begin o = {a[6:0], a[7]}; c = a[7]; end
            4'd11: begin o = {a[0], a[7:1]}; c = a[0]; end
            default: o = 8'hAA;
        endcase
        s = (op == 4'd8 || op == 4'd9) ? o[7] : ~o[7];
        return {c, ac, s, o};
    endfunction

    always_comb begin
        logic [10:0] r;
        r = alu_fn(alu_sel, alu_a, alu_b);
        alu_c   = r[10];
        alu_ac  = r[9];
        alu_s   = r[8];
        alu_out = r[7:0];
        alu_z   = (r[7:0] == 8'h00);
        alu_p   = ^r[7:0];
    end

    // Expected {flags, data} for a command with effective operand A.
    function automatic logic [13:0] exp_rsp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [10:0] r;
        logic [7:0]  o;
        logic        c, ac, s;
        if (op >= 4'd12) return {6'b100000, 8'h00};
        r  = alu_fn(op, a, b);
        o  = r[7:0];
        c  = (op >= 4'd8) ? r[10] : 1'b0;
        ac = (op == 4'd8 || op == 4'd9) ? r[9] : 1'b0;
        s  = (op == 4'd8 || op == 4'd9) ? r[8] : o[7];
        return {1'b0, ^o, (o == 8'h00), s, ac, c, o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    // One full command: accept, EXEC, RESP (optionally held), handshake.
    task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic use_acc, input logic wr_acc, input logic clr,
                           input logic early, input int hold);
        logic [7:0]  a_eff;
        logic [13:0] e;
        check("idle_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        cmd_use_acc = use_acc; cmd_wr_acc = wr_acc; acc_clr = clr; rsp_ready = early;
        if (clr) acc_m = 8'h00;
        a_eff = use_acc ? acc_m : a;
        e = exp_rsp(op, a_eff, b);
        @(posedge clk); #1;
        cmd_valid = 1'b0; acc_clr = 1'b0;
        check("exec_ready", {31'd0, cmd_ready}, 32'd0);
        check("exec_valid", {31'd0, rsp_valid}, 32'd0);
        check("alu_a", {24'd0, alu_a}, {24'd0, a_eff});
        check("alu_b", {24'd0, alu_b}, {24'd0, b});
        check("alu_sel", {28'd0, alu_sel}, (op >= 4'd12) ? 32'd0 : {28'd0, op});
        @(posedge clk); #1;
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_data", {24'd0, rsp_data}, {24'd0, e[7:0]});
        check("rsp_flags", {26'd0, rsp_flags}, {26'd0, e[13:8]});
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("hold_valid", {31'd0, rsp_valid}, 32'd1);
                check("hold_data", {18'd0, rsp_flags, rsp_data}, {18'd0, e});
                check("hold_ready", {31'd0, cmd_ready}, 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (wr_acc && !e[13]) acc_m = e[7:0];
        cnt_m = cnt_m + 16'd1;
        check("done_valid", {31'd0, rsp_valid}, 32'd0);
        check("done_ready", {31'd0, cmd_ready}, 32'd1);
        check("acc", {24'd0, acc}, {24'd0, acc_m});
        check("count", {16'd0, cmd_count}, {16'd0, cnt_m});
        $display("cmd op=%0d a=%02h b=%02h ua=%0b wa=%0b clr=%0b -> data=%02h flags=%06b acc=%02h cnt=%0d",
                 op, a_eff, b, use_acc, wr_acc, clr, rsp_data, rsp_flags, acc, cmd_count);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00;
        cmd_use_acc = 1'b0; cmd_wr_acc = 1'b0; acc_clr = 1'b0; rsp_ready = 1'b0;
        acc_m = 8'h00; cnt_m = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp", {18'd0, rsp_flags, rsp_data}, 32'd0);
        check("rst_alu", {12'd0, alu_a, alu_b, alu_sel}, 32'd0);
        check("rst_acc", {24'd0, acc}, 32'd0);
        check("rst_count", {16'd0, cmd_count}, 32'd0);

        // ADD with carry and half carry.
        run_cmd(4'd8, 8'hF8, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("add_data", {24'd0, rsp_data}, 32'h04);
        // Accumulator chain: three increments.
        for (int i = 0; i < 3; i++) run_cmd(4'd6, 8'h55, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("chain_acc", {24'd0, acc}, 32'h03);
        // Masking: shl, then rol.
        run_cmd(4'd5, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        check("shl_data", {24'd0, rsp_data}, 32'h02);
        run_cmd(4'd10, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("rol_data", {24'd0, rsp_data}, 32'h03);
        // Illegal op, even with wr_acc set.
        run_cmd(4'd13, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        // Backpressure for 5 cycles.
        run_cmd(4'd9, 8'h10, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 5);
        // Clear alone in IDLE, then clear with a command.
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        acc_m = 8'h00;
        check("clr_acc", {24'd0, acc}, 32'h00);
        run_cmd(4'd6, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        run_cmd(4'd6, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        check("clr_cmd_acc", {24'd0, acc}, 32'h01);

        // Randomized commands.
        for (int i = 0; i < 40; i++) begin
            run_cmd(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                    1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                    1'($urandom), $urandom_range(0, 3));
        end

        // Reset while a response is pending.
        cmd_valid = 1'b1; cmd_op = 4'd2; cmd_a = 8'h0F; cmd_b = 8'hF0;
        cmd_use_acc = 1'b0; cmd_wr_acc = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        acc_m = 8'h00; cnt_m = 16'h0000;
        check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        check("midrst_count", {16'd0, cmd_count}, {16'd0, cnt_m});
        check("midrst_acc", {24'd0, acc}, {24'd0, acc_m});
        run_cmd(4'd8, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
